// File: rtl/vc_arbiter.sv
// Moves VC0/VC1 head words into D0/D1; pop is combinational, push/data_out follow one cycle later.
// Backpressure: a head whose destination is almost-full is ineligible; VC_ARB_ROUND_ROBIN_EN enables round-robin grant.
module vc_arbiter #(
  parameter int BW    = 6,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active_in,
  input  logic             vc0_empty,
  input  logic             vc1_empty,
  input  logic [BW-1:0]    vc0_data,
  input  logic [BW-1:0]    vc1_data,
  input  logic             d0_almost_full,
  input  logic             d1_almost_full,
  output logic             vc0_pop,
  output logic             vc1_pop,
  output logic             d0_push,
  output logic             d1_push,
  output logic [BW-1:0]    data_out,
  output logic [CNT_W-1:0] cnt_d0,
  output logic [CNT_W-1:0] cnt_d1,
  output logic [1:0]       arb_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [1:0]    state, state_nxt;
  logic          vc0_elig, vc1_elig;
  logic          sched_ok, grant0, grant1, pop_any;
  logic [BW-1:0] pop_dat;

  // Each VC only looks at its own destination, so a blocked VC0 never holds up VC1.
  assign vc0_elig = !vc0_empty && !(vc0_data[BW-1] ? d1_almost_full : d0_almost_full);
  assign vc1_elig = !vc1_empty && !(vc1_data[BW-1] ? d1_almost_full : d0_almost_full);
  assign sched_ok = reset && active_in && (state == RUN);

`ifdef VC_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0 = VC0, 1 = VC1

  assign grant0 = sched_ok && vc0_elig && (!vc1_elig || last_grant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       last_grant <= 1'b1;
    else if (pop_any) last_grant <= grant1;
  end
`else
  assign grant0 = sched_ok && vc0_elig;
`endif

  assign grant1  = sched_ok && vc1_elig && !grant0;
  assign pop_any = grant0 || grant1;
  assign pop_dat = grant0 ? vc0_data : vc1_data;
  assign vc0_pop = grant0;
  assign vc1_pop = grant1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (active_in) state_nxt = RUN;
      RUN: begin
        if (!active_in)
          state_nxt = IDLE;
        else if ((!vc0_empty || !vc1_empty) && !vc0_elig && !vc1_elig)
          state_nxt = STALL;
      end
      STALL: begin
        if (!active_in)
          state_nxt = IDLE;
        else if (vc0_elig || vc1_elig)
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0_push  <= 1'b0;
      d1_push  <= 1'b0;
      data_out <= '0;
      cnt_d0   <= '0;
      cnt_d1   <= '0;
    end else begin
      d0_push <= pop_any && !pop_dat[BW-1];
      d1_push <= pop_any &&  pop_dat[BW-1];
      if (pop_any) begin
        data_out <= pop_dat;
        if (pop_dat[BW-1]) cnt_d1 <= cnt_d1 + CNT_W'(1);
        else               cnt_d0 <= cnt_d0 + CNT_W'(1);
      end
    end
  end

  assign arb_state = state;

endmodule

// File: tb/tb_vc_arbiter.sv
// Randomized and directed bench for vc_arbiter against a rule-level reference model.
module tb_vc_arbiter;
  localparam int BW    = 6;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             active_in;
  logic             vc0_empty, vc1_empty;
  logic [BW-1:0]    vc0_data, vc1_data;
  logic             d0_almost_full, d1_almost_full;
  logic             vc0_pop, vc1_pop, d0_push, d1_push;
  logic [BW-1:0]    data_out;
  logic [CNT_W-1:0] cnt_d0, cnt_d1;
  logic [1:0]       arb_state;

  vc_arbiter #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .active_in(active_in),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop), .d0_push(d0_push), .d1_push(d1_push),
    .data_out(data_out), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: 0 idle, 1 run, 2 stall; counters kept as plain integers mod 2^CNT_W.
  int          m_state;
  int          m_c0, m_c1;
  int          m_last;
  bit          m_push0, m_push1;
  logic [BW-1:0] m_dout;
  int          pops0, pops1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_c0 = 0; m_c1 = 0; m_last = 1;
    m_push0 = 0; m_push1 = 0; m_dout = '0;
  endtask

  function automatic bit eligible(input bit empty, input logic [BW-1:0] d, input bit af0, input bit af1);
    if (empty) return 0;
    return d[BW-1] ? !af1 : !af0;
  endfunction

  task automatic check_regs();
    chk("d0_push", 32'(d0_push), 32'(m_push0));
    chk("d1_push", 32'(d1_push), 32'(m_push1));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("cnt_d0", 32'(cnt_d0), 32'(m_c0));
    chk("cnt_d1", 32'(cnt_d1), 32'(m_c1));
    chk("arb_state", 32'(arb_state), 32'(m_state));
  endtask

  // Apply one cycle of inputs (called at posedge+1), check pops, then check registered results.
  task automatic cycle(input bit act, input bit e0, input bit e1,
                       input logic [BW-1:0] h0, input logic [BW-1:0] h1,
                       input bit af0, input bit af1);
    bit el0, el1, p0, p1;
    int nxt;
    logic [BW-1:0] w;
    active_in = act; vc0_empty = e0; vc1_empty = e1;
    vc0_data = h0; vc1_data = h1; d0_almost_full = af0; d1_almost_full = af1;
    #1;
    el0 = eligible(e0, h0, af0, af1);
    el1 = eligible(e1, h1, af0, af1);
    p0 = 0; p1 = 0;
    if (m_state == 1 && act) begin
      if (el0 && el1) begin
`ifdef VC_ARB_ROUND_ROBIN_EN
        p0 = (m_last == 1);
        p1 = !p0;
`else
        p0 = 1;
`endif
      end else begin
        p0 = el0;
        p1 = el1;
      end
    end
    chk("vc0_pop", 32'(vc0_pop), 32'(p0));
    chk("vc1_pop", 32'(vc1_pop), 32'(p1));
    nxt = m_state;
    if (!act) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1 && !(e0 && e1) && !el0 && !el1) nxt = 2;
    else if (m_state == 2 && (el0 || el1)) nxt = 1;
    @(posedge clk); #1;
    m_push0 = 0; m_push1 = 0;
    if (p0 || p1) begin
      w = p0 ? h0 : h1;
      m_dout = w;
      if (w[BW-1]) begin m_push1 = 1; m_c1 = (m_c1 + 1) % (1 << CNT_W); end
      else         begin m_push0 = 1; m_c0 = (m_c0 + 1) % (1 << CNT_W); end
      m_last = p0 ? 0 : 1;
      if (p0) pops0++; else pops1++;
    end
    m_state = nxt;
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("rst_vc0_pop", 32'(vc0_pop), 32'd0);
    chk("rst_vc1_pop", 32'(vc1_pop), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; active_in = 0; vc0_empty = 1; vc1_empty = 1;
    vc0_data = '0; vc1_data = '0; d0_almost_full = 0; d1_almost_full = 0;
    model_reset();
    #2;
    do_reset();

    // Single VC0 stream 05 then 21, VC1 empty.
    cycle(1, 1, 1, 6'h00, 6'h00, 0, 0);  // IDLE -> RUN, no pop
    cycle(1, 0, 1, 6'h05, 6'h00, 0, 0);
    chk("first_d0_data", 32'(data_out), 32'h05);
    cycle(1, 0, 1, 6'h21, 6'h00, 0, 0);
    chk("second_d1_push", 32'(d1_push), 32'd1);
    cycle(1, 1, 1, 6'h00, 6'h00, 0, 0);  // empty: stays RUN
    chk("cnt_d0_one", 32'(cnt_d0), 32'd1);
    chk("cnt_d1_one", 32'(cnt_d1), 32'd1);

    // Both VCs with D0-bound heads: policy decides.
    pops0 = 0; pops1 = 0;
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 6'h0A, 6'h0B, 0, 0);
`ifdef VC_ARB_ROUND_ROBIN_EN
    chk("rr_split_vc1", 32'(pops1), 32'd2);
`else
    chk("prio_vc1_none", 32'(pops1), 32'd0);
`endif
    for (int i = 0; i < 2; i++) cycle(1, 1, 0, 6'h00, 6'h0B, 0, 0);

    // VC0 blocked by D0 does not block VC1 heading to D1.
    cycle(1, 0, 0, 6'h03, 6'h23, 1, 0);
    chk("hol_data", 32'(data_out), 32'h23);

    // Stall then recover.
    cycle(1, 0, 0, 6'h0A, 6'h0B, 1, 0);
    chk("stall_state", 32'(arb_state), 32'd2);
    cycle(1, 0, 0, 6'h0A, 6'h0B, 1, 0);
    cycle(1, 0, 0, 6'h0A, 6'h0B, 0, 0);  // back to RUN, no pop
    chk("recover_state", 32'(arb_state), 32'd1);
    cycle(1, 0, 0, 6'h0A, 6'h0B, 0, 0);

    // In-flight push survives active_in drop.
    cycle(1, 0, 1, 6'h11, 6'h00, 0, 0);
    cycle(0, 0, 1, 6'h12, 6'h00, 0, 0);
    cycle(1, 1, 1, 6'h00, 6'h00, 0, 0);

    // 32+ D1 pushes: counter wraps.
    for (int i = 0; i < 34; i++) cycle(1, 1, 0, 6'h00, BW'(32 + (i % 32)), 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) != 0), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            BW'($urandom), BW'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    // Reset asserted mid-cycle while a pop is pending: word is dropped.
    cycle(1, 1, 1, 6'h00, 6'h00, 0, 0);
    active_in = 1; vc0_empty = 0; vc0_data = 6'h07; vc1_empty = 1;
    d0_almost_full = 0; d1_almost_full = 0;
    #1;
    chk("pre_reset_pop", 32'(vc0_pop), 32'd1);
    do_reset();
    chk("post_reset_push", 32'(d0_push), 32'd0);
    cycle(0, 1, 1, 6'h00, 6'h00, 0, 0);
    chk("post_reset_cnt", 32'(cnt_d0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transaction layer.
- Each cycle it selects at most one VC head word whose destination has room, pops it, and pushes it one cycle later into D0 or D1.
- The destination is selected by the word's MSB.
- The block is gated by the transaction state machine's active indication and exposes per-destination push counters for debug and verification.

Parameters:
- BW, 6, data word width in bits; bit BW-1 is the destination select (0 = D0, 1 = D1).
- CNT_W, 5, width of each per-destination push counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- active_in  input  1  1 = scheduling permitted (driven by the transaction state machine's active output).
- vc0_empty  input  1  VC0 FIFO empty.
- vc1_empty  input  1  VC1 FIFO empty.
- vc0_data  input  BW  VC0 head word (first-word fall-through, valid while !vc0_empty).
- vc1_data  input  BW  VC1 head word.
- d0_almost_full  input  1  D0 at or above its almost-full threshold.
- d1_almost_full  input  1  D1 at or above its almost-full threshold.
- vc0_pop  output  1  combinational pop strobe to VC0.
- vc1_pop  output  1  combinational pop strobe to VC1.
- d0_push  output  1  registered push strobe to D0.
- d1_push  output  1  registered push strobe to D1.
- data_out  output  BW  registered word presented with d0_push/d1_push.
- cnt_d0  output  CNT_W  registered count of words pushed to D0.
- cnt_d1  output  CNT_W  registered count of words pushed to D1.
- arb_state  output  2  current state: 0 IDLE, 1 RUN, 2 STALL.

Behaviour:
- Reset (reset=0, asynchronous): arb_state=IDLE; d0_push=d1_push=0; data_out=0; cnt_d0=cnt_d1=0; last_grant=VC1 (internal, RR only).
  - Pops are 0 while reset is low.
  - A word popped in the cycle reset asserts is dropped; its push never occurs.
- Eligibility: VCk is eligible when !vck_empty and the almost_full of the destination named by vck_data[BW-1] is 0.
- Pops are asserted only while arb_state=RUN and active_in=1. At most one pop per cycle.
- Grant policy, default strict priority:
  - VC0 is granted whenever eligible.
  - VC1 is granted only when VC0 is not eligible.
  - VC0 blocked by its destination does not block an eligible VC1 (no head-of-line coupling between VCs).
- Latency: pop in cycle N gives, at edge N+1, data_out = popped word and the push for its destination = 1 for exactly one cycle.
  - With no pop in cycle N, both pushes are 0 in cycle N+1 and data_out holds its last value.
- Counters: cnt_dX increments by 1 in the same edge that asserts dX_push. Wraps from 2^CNT_W-1 to 0. Cleared only by reset.
- State machine (registered):
  - IDLE -> RUN when active_in=1. No pop in the IDLE cycle; the first pop is possible in the next cycle.
  - RUN -> IDLE when active_in=0. No pop that cycle.
  - RUN -> STALL when active_in=1, at least one VC is non-empty, and neither is eligible. No pop that cycle.
  - RUN stays in RUN when both VCs are empty.
  - STALL -> IDLE when active_in=0.
  - STALL -> RUN when any VC becomes eligible. No pop in the STALL cycle.
- Deassertion of active_in: an in-flight push from the previous cycle's pop still completes.
- Simultaneous events:
  - Both VCs eligible: policy decides.
  - almost_full rising in the same cycle as an in-flight push does not cancel that push. D-FIFO thresholds are set to leave at least one free slot.

Optional Feature:
- Macro: VC_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both VCs are eligible, grant the VC not equal to last_grant.
  - last_grant updates on every pop.
  - A single eligible VC is always granted.
- Undefined: strict VC0 priority as above; last_grant is not implemented.

Test Plan:
- Reset low mid-run with a pop pending -> all outputs 0 and arb_state=0 immediately; no push after reset releases.
- active_in=1, VC0 holds 6'h05 then 6'h21, VC1 empty, no almost_full -> cycle after IDLE exit vc0_pop=1. Pushes follow one cycle after each pop: d0_push with data_out=6'h05, then d1_push with data_out=6'h21. cnt_d0=1, cnt_d1=1.
- Both VCs non-empty with D0-bound heads (6'h0A, 6'h0B), default build -> all VC0 words first, then VC1. With VC_ARB_ROUND_ROBIN_EN -> pops alternate VC0, VC1, VC0, ...
- VC0 head 6'h03 (D0), VC1 head 6'h23 (D1), d0_almost_full=1 -> vc1_pop=1, vc0_pop=0, then d1_push with 6'h23.
- Both heads D0-bound, d0_almost_full=1 -> arb_state=2 with no pops. Dropping almost_full -> RUN next cycle, pop one cycle later.
- 32 consecutive D1 pushes with CNT_W=5 -> cnt_d1 wraps 31 -> 0.
